// File: rtl/vga_pkg.sv
// vga_pkg: constants and types shared by the VGA sync generator and pixel stages.
//   H_ACTIVE / V_ACTIVE : visible pixels per line / visible lines per frame
//   rgb_t               : 4-bit-per-channel colour
//   COL_*               : palette used by the renderer
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COL_BLACK = rgb_t'(12'h000);
  localparam rgb_t COL_BG    = rgb_t'(12'h004);
  localparam rgb_t COL_BALL  = rgb_t'(12'hff0);
  localparam rgb_t COL_WHITE = rgb_t'(12'hfff);

endpackage

// File: rtl/ball_axis.sv
// ball_axis: position and direction of the ball along one screen axis.
// Moves STEP pixels per tick, clamping to 0..LIMIT and reversing at either end.
//   clk  : pixel clock
//   rst  : synchronous active-high reset (pos = 0, dir = +)
//   tick : one-cycle frame pulse
//   pos  : current position, 0..LIMIT
//   dir  : 1 = moving +, 0 = moving -
module ball_axis #(
  parameter int unsigned LIMIT = 624,
  parameter int unsigned STEP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  output logic [9:0] pos,
  output logic       dir
);

  localparam logic [10:0] Limit11 = 11'(LIMIT);
  localparam logic [10:0] Step11  = 11'(STEP);
  localparam logic [9:0]  Step10  = 10'(STEP);

  logic [9:0]  pos_q, pos_d;
  logic        dir_q, dir_d;
  logic [10:0] sum;

  // 11-bit sum so pos + STEP cannot wrap before the limit compare.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    sum   = {1'b0, pos_q} + Step11;
    if (tick) begin
      if (dir_q) begin
        if (sum >= Limit11) begin
          pos_d = Limit11[9:0];
          dir_d = 1'b0;
        end else begin
          pos_d = sum[9:0];
        end
      end else begin
        if ({1'b0, pos_q} <= Step11) begin
          pos_d = '0;
          dir_d = 1'b1;
        end else begin
          pos_d = pos_q - Step10;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;

endmodule

// File: rtl/vga_ball_renderer.sv
// vga_ball_renderer: draws a bouncing square ball on a solid background.
// Two-stage pipeline; syncs and colour leave exactly 2 cycles after the inputs.
//   clk, rst            : pixel clock, synchronous active-high reset
//   hsync_in, vsync_in  : active-low syncs from the sync generator
//   xpos, ypos          : pixel coordinates (blanking values wrap high)
//   hsync, vsync        : syncs delayed 2 cycles
//   red, green, blue    : 4-bit colour channels
// Optional macro VGA_BORDER_EN: paints a one-pixel white frame that overrides the ball.
module vga_ball_renderer
  import vga_pkg::*;
#(
  parameter int unsigned BALL_SIZE = 16,
  parameter int unsigned STEP      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  localparam logic [9:0] HAct  = 10'(H_ACTIVE);
  localparam logic [9:0] VAct  = 10'(V_ACTIVE);
  localparam logic [9:0] BSize = 10'(BALL_SIZE);

  // Frame tick: registered falling edge of vsync_in, always inside vertical blanking.
  logic vs_prev_q, tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      vs_prev_q <= vsync_in;
      tick_q    <= vs_prev_q & ~vsync_in;
    end
  end

  logic [9:0] bx, by;
  logic       dir_x, dir_y;

  ball_axis #(
    .LIMIT (H_ACTIVE - BALL_SIZE),
    .STEP  (STEP)
  ) u_axis_x (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_q),
    .pos  (bx),
    .dir  (dir_x)
  );

  ball_axis #(
    .LIMIT (V_ACTIVE - BALL_SIZE),
    .STEP  (STEP)
  ) u_axis_y (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_q),
    .pos  (by),
    .dir  (dir_y)
  );

  // Directions only steer the axis state; nothing downstream needs them.
  logic unused_dir;
  assign unused_dir = dir_x ^ dir_y;

  // Stage 1: classify the pixel.
  logic       active, in_ball;
  logic [9:0] rel_x, rel_y;

  // Unsigned differences: pixels left of / above the ball wrap large and fail the compare.
  assign active  = (xpos < HAct) && (ypos < VAct);
  assign rel_x   = xpos - bx;
  assign rel_y   = ypos - by;
  assign in_ball = (rel_x < BSize) && (rel_y < BSize);

  logic active_q, in_ball_q, hs1_q, vs1_q;

`ifdef VGA_BORDER_EN
  logic border, border_q;
  assign border = (xpos == '0) || (xpos == HAct - 10'd1) ||
                  (ypos == '0) || (ypos == VAct - 10'd1);

  always_ff @(posedge clk) begin
    if (rst) border_q <= 1'b0;
    else     border_q <= border;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      in_ball_q <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
    end else begin
      active_q  <= active;
      in_ball_q <= in_ball;
      hs1_q     <= hsync_in;
      vs1_q     <= vsync_in;
    end
  end

  // Stage 2: colour select, first match wins.
  rgb_t rgb_d, rgb_q;
  logic hs2_q, vs2_q;

  always_comb begin
    rgb_d = COL_BG;
    if (!active_q) begin
      rgb_d = COL_BLACK;
`ifdef VGA_BORDER_EN
    end else if (border_q) begin
      rgb_d = COL_WHITE;
`endif
    end else if (in_ball_q) begin
      rgb_d = COL_BALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= COL_BLACK;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign hsync = hs2_q;
  assign vsync = vs2_q;
  assign red   = rgb_q.r;
  assign green = rgb_q.g;
  assign blue  = rgb_q.b;

endmodule

// File: tb/tb_vga_ball_renderer.sv
// Bench for vga_ball_renderer: random and directed pixel streams compared with a
// behavioural model of the ball and palette, plus directed bounce/corner checks.
module tb_vga_ball_renderer;

  localparam int HA = 640;
  localparam int VA = 480;
  localparam int BS = 16;
  localparam int ST = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       hsync_in, vsync_in;
  logic [9:0] xpos, ypos;
  logic       hsync, vsync;
  logic [3:0] red, green, blue;

  always #5 clk = ~clk;

  vga_ball_renderer #(
    .BALL_SIZE (BS),
    .STEP      (ST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .xpos     (xpos),
    .ypos     (ypos),
    .hsync    (hsync),
    .vsync    (vsync),
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model of the ball.
  int mbx, mby;
  bit mdx, mdy;
  bit mprev_vs;
  int vs_stable;

  typedef struct {
    bit          hs;
    bit          vs;
    bit          col_ok;
    logic [11:0] rgb;
  } exp_t;

  exp_t q[$];

  task automatic axis_step(inout int p, inout bit d, input int lim);
    if (d) begin
      if (p + ST >= lim) begin
        p = lim;
        d = 1'b0;
      end else begin
        p = p + ST;
      end
    end else begin
      if (p <= ST) begin
        p = 0;
        d = 1'b1;
      end else begin
        p = p - ST;
      end
    end
  endtask

  function automatic logic [11:0] model_rgb(input int x, input int y);
    if (!(x < HA && y < VA)) return 12'h000;
`ifdef VGA_BORDER_EN
    if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return 12'hfff;
`endif
    if (x >= mbx && x < mbx + BS && y >= mby && y < mby + BS) return 12'hff0;
    return 12'h004;
  endfunction

  // One pixel clock: check the outputs of the pixel driven two cycles ago, then
  // drive a new pixel. Colour is only judged once vsync_in has been steady long
  // enough that no ball update can be in flight.
  task automatic step(input bit hs, input bit vs, input int x, input int y);
    exp_t e;
    @(negedge clk);
    if (q.size() == 2) begin
      e = q.pop_front();
      check("hsync", 32'(hsync), 32'(e.hs));
      check("vsync", 32'(vsync), 32'(e.vs));
      if (e.col_ok) check("rgb", {20'd0, red, green, blue}, {20'd0, e.rgb});
    end
    rst      = 1'b0;
    hsync_in = hs;
    vsync_in = vs;
    xpos     = 10'(x);
    ypos     = 10'(y);
    if (mprev_vs && !vs) begin
      axis_step(mbx, mdx, HA - BS);
      axis_step(mby, mdy, VA - BS);
    end
    vs_stable = (vs == mprev_vs) ? vs_stable + 1 : 1;
    mprev_vs  = vs;
    e.hs      = hs;
    e.vs      = vs;
    e.col_ok  = (vs_stable >= 4);
    e.rgb     = model_rgb(x, y);
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
    xpos     = 10'($urandom);
    ypos     = 10'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rgb", {20'd0, red, green, blue}, 32'd0);
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      xpos     = 10'($urandom);
      ypos     = 10'($urandom);
    end
    check("rst_bx", 32'(dut.u_axis_x.pos_q), 32'd0);
    check("rst_by", 32'(dut.u_axis_y.pos_q), 32'd0);
    check("rst_dx", 32'(dut.u_axis_x.dir_q), 32'd1);
    check("rst_dy", 32'(dut.u_axis_y.dir_q), 32'd1);
    mbx = 0; mby = 0; mdx = 1'b1; mdy = 1'b1;
    mprev_vs  = 1'b1;
    vs_stable = 0;
    q.delete();
  endtask

  task automatic rand_pix(output int x, output int y);
    case ($urandom_range(0, 3))
      0: begin x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023)); end
      1: begin x = int'($urandom_range(0, HA - 1)); y = int'($urandom_range(0, VA - 1)); end
      default: begin
        x = (mbx + int'($urandom_range(0, BS + 4)) - 2) & 1023;
        y = (mby + int'($urandom_range(0, BS + 4)) - 2) & 1023;
      end
    endcase
  endtask

  task automatic do_ticks(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      rand_pix(x, y);
      step(1'($urandom), 1'b1, x, y);
      step(1'($urandom), 1'b0, x, y);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 100, 100);
  endtask

  task automatic check_ball(input string tag);
    check({tag, "_bx"}, 32'(dut.u_axis_x.pos_q), 32'(mbx));
    check({tag, "_by"}, 32'(dut.u_axis_y.pos_q), 32'(mby));
    check({tag, "_dx"}, 32'(dut.u_axis_x.dir_q), 32'(mdx));
    check({tag, "_dy"}, 32'(dut.u_axis_y.dir_q), 32'(mdy));
  endtask

  initial begin
    int x, y;
    rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; xpos = '0; ypos = '0;
    do_reset();

    // Directed: background, hsync pulse with ball pixel, blanking, border spots.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 100, 100);
    step(1'b0, 1'b1, 5, 5);
    step(1'b1, 1'b1, 1000, 10);
    step(1'b1, 1'b1, 100, 100);
    step(1'b1, 1'b1, 639, 200);
    step(1'b1, 1'b1, 0, 0);
    step(1'b1, 1'b1, 15, 15);
    step(1'b1, 1'b1, 16, 15);
    step(1'b1, 1'b1, 5, 979);
    step(1'b1, 1'b1, 864, 5);
    step(1'b1, 1'b1, 200, 479);
    step(1'b1, 1'b1, 200, 480);

    // Right-edge bounce.
    do_ticks(311);
    check_ball("t311");
    check("t311_bx_abs", 32'(dut.u_axis_x.pos_q), 32'd622);
    do_ticks(1);
    check_ball("t312");
    check("t312_bx_abs", 32'(dut.u_axis_x.pos_q), 32'd624);
    do_ticks(1);
    check_ball("t313");

    // Random pixels with steady vsync, ball wherever it now is.
    for (int i = 0; i < 1500; i++) begin
      rand_pix(x, y);
      step(1'($urandom), 1'b1, x, y);
    end

    // Random vsync activity moves the ball between checked pixels.
    for (int i = 0; i < 3000; i++) begin
      rand_pix(x, y);
      step(1'($urandom), ($urandom_range(0, 15) == 0) ? ~mprev_vs : mprev_vs, x, y);
    end

    // Reset mid-frame, then the simultaneous corner at tick 9047 -> 9048.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 3, 3);
    do_ticks(9047);
    check_ball("t9047");
    do_ticks(1);
    check_ball("corner");
    check("corner_bx_abs", 32'(dut.u_axis_x.pos_q), 32'd624);
    check("corner_by_abs", 32'(dut.u_axis_y.pos_q), 32'd464);

    for (int i = 0; i < 500; i++) begin
      rand_pix(x, y);
      step(1'($urandom), 1'b1, x, y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
